// File: rtl/disp_dither.sv
// disp_dither: 12->8 bit RGB reduction with 4x4 Bayer ordered dither, 2-cycle pipeline.
// Optional DISP_DITHER_TEMPORAL_EN rotates the matrix phase every frame.
module disp_dither #(
    parameter int IN_DW   = 12,
    parameter int OUT_DW  = 8,
    parameter int HCNT_BW = 11,
    parameter int VCNT_BW = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync_in,
    input  logic              de_in,
    input  logic [IN_DW-1:0]  r_in,
    input  logic [IN_DW-1:0]  g_in,
    input  logic [IN_DW-1:0]  b_in,
    input  logic              reg_dither_en,
    output logic              vsync_out,
    output logic              de_out,
    output logic [OUT_DW-1:0] r_out,
    output logic [OUT_DW-1:0] g_out,
    output logic [OUT_DW-1:0] b_out
);
    // Bayer thresholds, entry {row,col} at nibble index 4*row+col
    localparam logic [63:0] BAYER = 64'h5D7F91B36E4CA280;
    logic               vs_d1_q, de_d1_q, dith_act_q, dith_act_d, vs_rise, de_fall;
    logic [HCNT_BW-1:0] h_cnt_q, h_cnt_d;
    logic [VCNT_BW-1:0] v_cnt_q, v_cnt_d;
    logic [1:0]         ofs, row, col;
    logic [3:0]         thr, thr1_q;
    logic [IN_DW-1:0]   r1_q, g1_q, b1_q;
    logic               de1_q, vs1_q;
`ifdef DISP_DITHER_TEMPORAL_EN
    logic [1:0] frm_cnt_q;
    always_ff @(posedge clk)
        if (rst) frm_cnt_q <= 2'd0;
        else if (vs_rise) frm_cnt_q <= frm_cnt_q + 2'd1;
    assign ofs = frm_cnt_q;
`else
    assign ofs = 2'd0;
`endif
    function automatic logic [OUT_DW-1:0] dith(input logic [IN_DW-1:0] px, input logic [3:0] t,
                                               input logic act);
        logic [OUT_DW-1:0] base;
        base = px[IN_DW-1:IN_DW-OUT_DW];
        return base + OUT_DW'(act && (px[IN_DW-OUT_DW-1:0] > t) && !(&base));
    endfunction
    always_comb begin
        vs_rise    = vsync_in & ~vs_d1_q;
        de_fall    = ~de_in & de_d1_q;
        h_cnt_d    = de_in ? h_cnt_q + HCNT_BW'(1) : '0;
        v_cnt_d    = vs_rise ? '0 : de_fall ? v_cnt_q + VCNT_BW'(1) : v_cnt_q;
        dith_act_d = vs_rise ? reg_dither_en : dith_act_q;
        row        = v_cnt_q[1:0] + ofs;
        col        = h_cnt_q[1:0] + ofs;
        thr        = BAYER[{row, col, 2'b00} +: 4];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d1_q    <= 1'b0;
            de_d1_q    <= 1'b0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            dith_act_q <= 1'b0;
            r1_q       <= '0;
            g1_q       <= '0;
            b1_q       <= '0;
            thr1_q     <= '0;
            de1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            vsync_out  <= 1'b0;
            de_out     <= 1'b0;
            r_out      <= '0;
            g_out      <= '0;
            b_out      <= '0;
        end else begin
            vs_d1_q    <= vsync_in;
            de_d1_q    <= de_in;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            dith_act_q <= dith_act_d;
            r1_q       <= r_in;
            g1_q       <= g_in;
            b1_q       <= b_in;
            thr1_q     <= thr;
            de1_q      <= de_in;
            vs1_q      <= vsync_in;
            vsync_out  <= vs1_q;
            de_out     <= de1_q;
            r_out      <= de1_q ? dith(r1_q, thr1_q, dith_act_q) : '0;
            g_out      <= de1_q ? dith(g1_q, thr1_q, dith_act_q) : '0;
            b_out      <= de1_q ? dith(b1_q, thr1_q, dith_act_q) : '0;
        end
    end
endmodule

// File: tb/tb_disp_dither.sv
// tb_disp_dither: table-driven frames, hand-written corner sequences and random traffic vs a reference model.
module tb_disp_dither;
    logic       clk = 1'b0, rst = 1'b1, vsync_in = 1'b0, de_in = 1'b0, reg_dither_en = 1'b0;
    logic [11:0] r_in = '0, g_in = '0, b_in = '0;
    logic       vsync_out, de_out;
    logic [7:0] r_out, g_out, b_out;

    disp_dither dut (
        .clk(clk), .rst(rst), .vsync_in(vsync_in), .de_in(de_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .reg_dither_en(reg_dither_en),
        .vsync_out(vsync_out), .de_out(de_out), .r_out(r_out), .g_out(g_out), .b_out(b_out)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    int tmat[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
    int row = 0, col = 0, frm = 0;
    bit act = 0, pvs = 0, pde = 0;
    logic [25:0] pipe = '0, exp_out = '0;
    logic [7:0] cap[$];

    typedef struct {
        logic [11:0] px;
        bit          en;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          n_hi;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [7:0] ref_px(int x, int thr, bit a);
        int v;
        v = x / 16 + ((a && (x % 16) > thr) ? 1 : 0);
        return 8'(v > 255 ? 255 : v);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    task automatic step(bit rs, bit vs, bit de, logic [11:0] rr, logic [11:0] gg, logic [11:0] bb);
        bit vr, df, an;
        int thr, o;
        rst = rs; vsync_in = vs; de_in = de; r_in = rr; g_in = gg; b_in = bb;
        @(posedge clk);
        #1;
        if (rs) begin
            exp_out = '0; pipe = '0; row = 0; col = 0; frm = 0; act = 0; pvs = 0; pde = 0;
        end else begin
            vr = vs && !pvs;
            df = !de && pde;
            an = vr ? reg_dither_en : act;
`ifdef DISP_DITHER_TEMPORAL_EN
            o = frm % 4;
`else
            o = 0;
`endif
            thr = tmat[(row + o) % 4][(col + o) % 4];
            exp_out = pipe;
            pipe = {vs, de, de ? ref_px(int'(rr), thr, an) : 8'h00,
                    de ? ref_px(int'(gg), thr, an) : 8'h00, de ? ref_px(int'(bb), thr, an) : 8'h00};
            col = de ? (col + 1) % 2048 : 0;
            row = vr ? 0 : df ? (row + 1) % 2048 : row;
            if (vr) frm++;
            act = an; pvs = vs; pde = de;
        end
        check("pipe {vs,de,r,g,b}", {6'b0, vsync_out, de_out, r_out, g_out, b_out}, {6'b0, exp_out});
        if (de_out) cap.push_back(r_out);
    endtask

    task automatic blank(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 12'h0, 12'h0, 12'h0);
    endtask

    task automatic frame(logic [11:0] px, int lines, int width, int en_line);
        cap.delete();
        step(0, 1, 0, 12'h0, 12'h0, 12'h0);
        step(0, 1, 0, 12'h0, 12'h0, 12'h0);
        blank(1);
        for (int l = 0; l < lines; l++) begin
            if (l == en_line) reg_dither_en = 1;
            for (int w = 0; w < width; w++) step(0, 0, 1, px, px, px);
            blank(2);
        end
        blank(2);
    endtask

    initial begin
        int n_hi, n_bad, n00;
        bit v, e;
        tbl = '{'{12'hABC, 0, 8'hAB, 8'hAB, 16}, '{12'h008, 1, 8'h00, 8'h01, 8},
                '{12'hFFF, 1, 8'hFF, 8'hFF, 16}, '{12'hFF0, 1, 8'hFF, 8'hFF, 16},
                '{12'hEFF, 1, 8'hEF, 8'hF0, 15}, '{12'h00F, 1, 8'h00, 8'h01, 15},
                '{12'h001, 1, 8'h00, 8'h01, 1},  '{12'h000, 1, 8'h00, 8'h01, 0}};
        for (int i = 0; i < 3; i++) step(1, 0, 0, 12'h0, 12'h0, 12'h0);
        for (int i = 0; i < 8; i++) begin
            reg_dither_en = tbl[i].en;
            frame(tbl[i].px, 4, 4, -1);
            n_hi = 0; n_bad = 0;
            foreach (cap[k]) begin
                if (cap[k] == tbl[i].hi) n_hi++;
                else if (cap[k] != tbl[i].lo) n_bad++;
            end
            check($sformatf("tbl%0d pixel count", i), cap.size(), 16);
            check($sformatf("tbl%0d hi count", i), n_hi, tbl[i].n_hi);
            check($sformatf("tbl%0d out of range", i), n_bad, 0);
        end
`ifndef DISP_DITHER_TEMPORAL_EN
        reg_dither_en = 1;
        frame(12'h008, 1, 2, -1);
        check("r0c0 of 0x008", cap[0], 8'h01);
        check("r0c1 of 0x008", cap[1], 8'h00);
`endif
        // enable requested mid-frame must wait for the next vsync rise
        reg_dither_en = 0;
        frame(12'h00F, 4, 4, 2);
        n_hi = 0;
        foreach (cap[k]) if (cap[k] == 8'h01) n_hi++;
        check("mid-frame enable ones", n_hi, 0);
        frame(12'h00F, 4, 4, -1);
        n_hi = 0;
        foreach (cap[k]) if (cap[k] == 8'h01) n_hi++;
        check("next-frame enable ones", n_hi, 15);
        // one-cycle de gap, then vsync rise coincident with de fall
        reg_dither_en = 1;
        step(0, 1, 0, 12'h0, 12'h0, 12'h0);
        blank(1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 12'h008, 12'h009, 12'h00A);
        blank(1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 12'h008, 12'h00C, 12'h00E);
        step(0, 1, 0, 12'h0, 12'h0, 12'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 12'h008, 12'h00D, 12'h00B);
        blank(3);
        // pixel (0,0) over four frames with a constant 0x001
        n00 = 0;
        for (int f = 0; f < 4; f++) begin
            frame(12'h001, 1, 1, -1);
            if (cap[0] == 8'h01) n00++;
        end
`ifdef DISP_DITHER_TEMPORAL_EN
        check("pixel(0,0) ones over 4 frames", n00, 1);
`else
        check("pixel(0,0) ones over 4 frames", n00, 4);
`endif
        v = 0; e = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) v = ~v;
            if ($urandom_range(0, 49) == 0) e = ~e;
            reg_dither_en = e;
            step($urandom_range(0, 299) == 0, v, $urandom_range(0, 3) != 0,
                 12'($urandom), 12'($urandom), 12'($urandom));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
